// File: rtl/float_result_to_int.sv
// float_result_to_int
//   Downstream stage of the floating-point adder. Each valid IEEE-754 single
//   Result is converted to a signed 32-bit integer. Rounding is
//   round-to-nearest-even, and out-of-range values saturate. The converted
//   value and its flags go into a small FIFO with a valid/ready interface.
//   The adder cannot be stalled, so a result that reaches a full FIFO with no
//   pop in the same cycle is dropped and counted.
//
// Ports
//   Clock        single clock, all logic on posedge
//   Reset        synchronous, active-low reset
//   Result       float from adder: sign[31], exp[30:23], frac[22:0]
//   ResultValid  Result valid this cycle (no backpressure possible)
//   IntOut       signed integer at FIFO head (0 when empty)
//   Inexact      head entry: rounding discarded nonzero bits
//   Invalid      head entry: NaN, Inf or out-of-range (saturated)
//   IntValid     FIFO non-empty
//   IntReady     consumer takes head when IntValid && IntReady
//   Count        FIFO occupancy
//   DropCount    saturating count of dropped results
module float_result_to_int #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [31:0]              Result,
  input  logic                     ResultValid,
  output logic [31:0]              IntOut,
  output logic                     Inexact,
  output logic                     Invalid,
  output logic                     IntValid,
  input  logic                     IntReady,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [DROP_W-1:0]        DropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] CLS_ZERO   = 2'd0;
  localparam logic [1:0] CLS_NORMAL = 2'd1;
  localparam logic [1:0] CLS_INF    = 2'd2;
  localparam logic [1:0] CLS_NAN    = 2'd3;

  // ---------------- Stage 1: unpack ----------------
  logic              s1Valid;
  logic              s1Sign;
  logic signed [8:0] s1Exp;
  logic [23:0]       s1Mant;
  logic [1:0]        s1Class;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s1Valid <= 1'b0;
      s1Sign  <= 1'b0;
      s1Exp   <= '0;
      s1Mant  <= '0;
      s1Class <= CLS_ZERO;
    end else begin
      s1Valid <= ResultValid;
      if (ResultValid) begin
        s1Sign <= Result[31];
        s1Exp  <= $signed({1'b0, Result[30:23]}) - 9'sd127;
        // Hidden bit is zero for exp==0, so the zero class still carries
        // the denormal fraction for the Inexact decision.
        s1Mant <= {|Result[30:23], Result[22:0]};
        if (Result[30:23] == 8'd0)
          s1Class <= CLS_ZERO;
        else if (Result[30:23] == 8'hFF)
          s1Class <= (Result[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        else
          s1Class <= CLS_NORMAL;
      end
    end
  end

  // ---------------- Stage 2: shift, round, saturate ----------------
  logic [4:0]  rShift;
  logic [3:0]  lShift;
  logic [47:0] shifted;
  logic        guardBit;
  logic        stickyBit;
  logic        roundUp;
  logic [32:0] mag;
  logic        overflow;
  logic        rInexact;
  logic [31:0] cInt;
  logic        cInexact;
  logic        cInvalid;

  // Valid only in the branches that use them: 0<=E<=23 and 24<=E<=31.
  assign rShift = 5'd23 - s1Exp[4:0];
  assign lShift = s1Exp[3:0] - 4'd7;

  always_comb begin
    shifted   = '0;
    guardBit  = 1'b0;
    stickyBit = 1'b0;
    roundUp   = 1'b0;
    mag       = '0;
    overflow  = 1'b0;
    rInexact  = 1'b0;
    cInt      = '0;
    cInexact  = 1'b0;
    cInvalid  = 1'b0;
    case (s1Class)
      CLS_ZERO: begin
        cInexact = |s1Mant[22:0];
      end
      CLS_NAN: begin
        cInt     = 32'h8000_0000;
        cInvalid = 1'b1;
      end
      CLS_INF: begin
        cInt     = s1Sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        cInvalid = 1'b1;
      end
      default: begin
        if (s1Exp < 9'sd0) begin
          // Only E=-1 with a nonzero fraction lies strictly above 0.5.
          mag      = {32'd0, (s1Exp == -9'sd1) && (|s1Mant[22:0])};
          rInexact = 1'b1;
        end else if (s1Exp <= 9'sd23) begin
          shifted   = {s1Mant, 24'd0} >> rShift;
          guardBit  = shifted[23];
          stickyBit = |shifted[22:0];
          roundUp   = guardBit & (stickyBit | shifted[24]);
          mag       = {9'd0, shifted[47:24]} + {32'd0, roundUp};
          rInexact  = guardBit | stickyBit;
        end else if (s1Exp <= 9'sd31) begin
          mag = {9'd0, s1Mant} << lShift;
        end else begin
          overflow = 1'b1;
        end

        if (overflow || (!s1Sign && (mag[32:31] != 2'b00)) ||
            (s1Sign && (mag > 33'h0_8000_0000))) begin
          cInt     = s1Sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
          cInvalid = 1'b1;
        end else begin
          cInt     = s1Sign ? (32'd0 - mag[31:0]) : mag[31:0];
          cInexact = rInexact;
        end
      end
    endcase
  end

  logic        s2Valid;
  logic [33:0] s2Data;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      s2Valid <= 1'b0;
      s2Data  <= '0;
    end else begin
      s2Valid <= s1Valid;
      if (s1Valid)
        s2Data <= {cInt, cInexact, cInvalid};
    end
  end

  // ---------------- Output FIFO ----------------
  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          push;
  logic          pop;
  logic          drop;
  logic [33:0]   headData;

  assign IntValid = (Count != '0);
  assign pop      = IntValid && IntReady;
  assign push     = s2Valid && ((Count != CW'(DEPTH)) || pop);
  assign drop     = s2Valid && !push;
  assign headData = mem[rdPtr];

  assign IntOut  = IntValid ? headData[33:2] : '0;
  assign Inexact = IntValid && headData[1];
  assign Invalid = IntValid && headData[0];

  always_ff @(posedge Clock) begin
    if (Reset && push)
      mem[wrPtr] <= s2Data;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      Count     <= '0;
      DropCount <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap on natural overflow.
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)
        Count <= Count + 1'b1;
      else if (pop && !push)
        Count <= Count - 1'b1;
      if (drop && (DropCount != '1))
        DropCount <= DropCount + 1'b1;
    end
  end

endmodule

// File: doc/float_result_to_int.md
Name: float_result_to_int

Overview:
- Downstream stage of the floating-point adder. Consumes the adder's Result/ResultValid stream (IEEE-754 single, floatingpoint::float).
- Converts each result to a signed 32-bit integer, rounding to nearest-even with saturation, and reports exception flags.
- Buffers converted values in a small FIFO with a valid/ready output, because the adder cannot be stalled.
- Results arriving while the FIFO cannot accept them are dropped and counted.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, >=2)
- DROP_W, 16, width of drop counter

Ports:
- Clock  input  1  single clock; all logic on posedge
- Reset  input  1  synchronous, active-low reset
- Result  input  32  float from adder: sign[31], exp[30:23], frac[22:0]
- ResultValid  input  1  Result valid this cycle; no backpressure possible
- IntOut  output  32  signed integer at FIFO head
- Inexact  output  1  head entry: rounding discarded nonzero bits
- Invalid  output  1  head entry: NaN, Inf or out-of-range (saturated)
- IntValid  output  1  FIFO non-empty
- IntReady  input  1  consumer accepts head when IntValid&&IntReady
- Count  output  $clog2(DEPTH)+1  FIFO occupancy
- DropCount  output  DROP_W  saturating count of dropped results

Behaviour:
- Reset (Reset==0 at posedge):
  - Pipeline valids, FIFO pointers, Count and DropCount go to 0.
  - IntValid=0; IntOut, Inexact and Invalid read 0.
  - Reset mid-operation discards all in-flight and buffered entries.
- Pipeline: 2 non-stalling stages.
  - S1 registers sign, unbiased exponent E=exp-127, mantissa {1,frac}, and class (zero/denormal, normal, Inf, NaN).
  - S2 computes the shift, rounding and saturation, then writes the FIFO.
- Latency: ResultValid sampled at edge k; entry written at edge k+2; IntValid high after edge k+2 if the FIFO was empty. Throughput 1/cycle.
- Conversion rules:
  - exp==0: result 0. Denormals flush to 0; Inexact=1 iff frac!=0.
  - exp==255, frac!=0 (NaN): 0x8000_0000, Invalid=1.
  - Inf: +Inf gives 0x7FFF_FFFF, -Inf gives 0x8000_0000; Invalid=1.
  - E<0: magnitude <1; round-to-nearest-even gives 0 or 1 (0.5 gives 0); Inexact=1.
  - 0<=E<=23: right-shift mantissa by 23-E and round RNE on the guard/sticky bits; Inexact=1 iff any discarded bit is nonzero.
  - E>23: left-shift by E-23; exact.
  - Rounding may carry into a new bit; apply saturation after rounding.
  - Saturation, positive: rounded magnitude >= 2^31 gives 0x7FFF_FFFF, Invalid=1.
  - Saturation, negative: magnitude > 2^31 gives 0x8000_0000, Invalid=1. Exactly -2^31 is exact: no flags.
  - Negative results: two's complement of the rounded magnitude. -0.0 gives 0.
  - Inexact=0 whenever Invalid=1.
- FIFO:
  - Push = S2 valid && (Count<DEPTH || pop this cycle). Pop = IntValid && IntReady.
  - Simultaneous push and pop when full: both occur, Count unchanged.
  - Push and pop when empty: the entry is written; no bypass; IntValid rises the next cycle.
  - Pointers wrap modulo DEPTH.
  - IntOut, Inexact and Invalid are stable while IntValid && !IntReady.
- Drop: S2 valid while full and no pop means the entry is discarded. DropCount increments and saturates at all-ones; it never wraps.
- ResultValid=0: Result is ignored and no state changes except pop.

Test Plan:
- Integer and tie inputs, IntReady=1:
  - 0x40E00000 (7.0) -> 7, flags 0, IntValid exactly 2 cycles after input.
  - 0x40900000 (4.5) -> 4, Inexact=1.
  - 0x40B00000 (5.5) -> 6, Inexact=1.
- Negative, fractional and boundary inputs:
  - 0xBFC00000 (-1.5) -> 0xFFFFFFFE, Inexact=1.
  - 0x3F000000 (0.5) -> 0, Inexact=1.
  - 0xCF000000 (-2^31) -> 0x80000000, flags 0.
- Saturation and special values:
  - 0x4F32D05E (3e9) -> 0x7FFFFFFF, Invalid=1.
  - 0x7FC00000 (NaN) -> 0x80000000, Invalid=1.
  - 0xFF800000 (-Inf) -> 0x80000000, Invalid=1.
  - 0x00000001 (denormal) -> 0, Inexact=1.
- Backpressure, DEPTH=4, IntReady=0:
  - 6 back-to-back valid results -> Count=4, DropCount=2, head equals the first result.
  - Then IntReady=1 -> the 4 entries drain in order and IntValid falls.
- Full-FIFO push/pop: with FIFO full, assert IntReady and feed one new result in the same cycle -> no drop, Count stays 4, ordering preserved.
- Reset mid-stream: 2 results in the pipeline and 3 in the FIFO, pull Reset low for 1 cycle -> Count=0, IntValid=0, DropCount=0, and no stale entry appears afterwards.
